scr1_scu_rst_req_ctrl: RTL and testbench

Reset-request controller between the Debug Module and the System Control Unit. It turns the DM's level requests (non-debug-module reset and hart reset) into the SCU's synchronous active-low inputs `ndm_rst_n` and `hart_rst_n`. It guarantees a minimum assertion width and closes the loop by watching the SCU's `core_rst_n` and `core_rst_n_qlfy`. It reports completion (`havereset`), progress (`rst_busy`) and a stuck-reset condition (`rst_timeout`) back to the DM.

---
 rtl/scr1_scu_rst_req_ctrl.sv | 158 +++++++++++++++
 tb/tb_scr1_scu_rst_req_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_scu_rst_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scr1_scu_rst_req_ctrl
// Purpose  : Turns DM reset requests into minimum-width SCU reset pulses and
//            tracks core reset completion and timeouts.
// Revision : 1.0
// ============================================================================
module scr1_scu_rst_req_ctrl #(
    parameter int SCR1_RSTREQ_MIN_LEN = 8,
    parameter int SCR1_RSTREQ_TIMEOUT = 255
) (
    input  logic clk,
    input  logic pwrup_rst_n_sync,
    input  logic dm_ndmreset_req,
    input  logic dm_hartreset_req,
    input  logic core_rst_n,
    input  logic core_rst_n_qlfy,
    input  logic havereset_clr,
    output logic ndm_rst_n,
    output logic hart_rst_n,
    output logic havereset,
    output logic rst_busy,
    output logic rst_timeout
);
    localparam int MIN_W = $clog2(SCR1_RSTREQ_MIN_LEN + 1);
    localparam int TMO_W = $clog2(SCR1_RSTREQ_TIMEOUT + 1);

    localparam logic [MIN_W-1:0] c_min_max  = MIN_W'(SCR1_RSTREQ_MIN_LEN);
    localparam logic [MIN_W-1:0] c_min_last = MIN_W'(SCR1_RSTREQ_MIN_LEN - 1);
    localparam logic [TMO_W-1:0] c_tmo_max  = TMO_W'(SCR1_RSTREQ_TIMEOUT);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(SCR1_RSTREQ_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_req_dly;   // [0] ndm, [1] hart
    logic             r_ndm_sel;
    logic             r_hart_sel;
    logic             r_core_seen;
    logic [MIN_W-1:0] r_min_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic w_trig_ndm;
    logic w_trig_hart;
    logic w_seen;
    logic w_min_done;
    logic w_tmo_done;
    logic w_req_low;
    logic w_upgrade;
    logic w_core_up;

    assign w_trig_ndm  = dm_ndmreset_req  & ~r_req_dly[0];
    assign w_trig_hart = dm_hartreset_req & ~r_req_dly[1];
    // Decisions account for this cycle's count/observation so widths are exact.
    assign w_seen      = r_core_seen | ~core_rst_n;
    assign w_min_done  = (r_min_cnt >= c_min_last);
    assign w_tmo_done  = (r_tmo_cnt >= c_tmo_last);
    assign w_req_low   = (~r_ndm_sel  | ~dm_ndmreset_req) &
                         (~r_hart_sel | ~dm_hartreset_req);
    assign w_upgrade   = w_trig_ndm & r_hart_sel & ~r_ndm_sel;
    assign w_core_up   = core_rst_n & core_rst_n_qlfy;

    always_ff @(posedge clk or negedge pwrup_rst_n_sync) begin
        if (!pwrup_rst_n_sync) begin
            r_state     <= ST_IDLE;
            r_req_dly   <= 2'b00;
            r_ndm_sel   <= 1'b0;
            r_hart_sel  <= 1'b0;
            r_core_seen <= 1'b0;
            r_min_cnt   <= '0;
            r_tmo_cnt   <= '0;
            ndm_rst_n   <= 1'b1;
            hart_rst_n  <= 1'b1;
            havereset   <= 1'b1;
            rst_busy    <= 1'b0;
            rst_timeout <= 1'b0;
        end else begin
            r_req_dly <= {dm_hartreset_req, dm_ndmreset_req};
            if (havereset_clr) begin
                havereset <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    ndm_rst_n  <= 1'b1;
                    hart_rst_n <= 1'b1;
                    if (w_trig_ndm || w_trig_hart) begin
                        r_state     <= ST_ASSERT;
                        r_ndm_sel   <= w_trig_ndm;
                        r_hart_sel  <= w_trig_hart;
                        r_core_seen <= 1'b0;
                        r_min_cnt   <= '0;
                        r_tmo_cnt   <= '0;
                        rst_timeout <= 1'b0;
                        rst_busy    <= 1'b1;
                        ndm_rst_n   <= ~w_trig_ndm;
                        hart_rst_n  <= ~w_trig_hart;
                    end
                end

                ST_ASSERT: begin
                    r_core_seen <= w_seen;
                    if (r_min_cnt < c_min_max) begin
                        r_min_cnt <= r_min_cnt + MIN_W'(1);
                    end
                    if (!w_seen && (r_tmo_cnt < c_tmo_max)) begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end

                    if (!w_seen && w_tmo_done) begin
                        r_state     <= ST_RELEASE;
                        r_tmo_cnt   <= '0;
                        rst_timeout <= 1'b1;
                        ndm_rst_n   <= 1'b1;
                        hart_rst_n  <= 1'b1;
                    end else if (w_upgrade) begin
                        r_ndm_sel <= 1'b1;
                        r_min_cnt <= '0;
                        ndm_rst_n <= 1'b0;
                    end else if (w_min_done && w_seen && w_req_low) begin
                        r_state    <= ST_RELEASE;
                        r_tmo_cnt  <= '0;
                        ndm_rst_n  <= 1'b1;
                        hart_rst_n <= 1'b1;
                    end
                end

                ST_RELEASE: begin
                    ndm_rst_n  <= 1'b1;
                    hart_rst_n <= 1'b1;
                    if (w_core_up) begin
                        r_state   <= ST_IDLE;
                        havereset <= 1'b1;
                        rst_busy  <= 1'b0;
                    end else if (w_tmo_done) begin
                        r_state     <= ST_IDLE;
                        rst_timeout <= 1'b1;
                        rst_busy    <= 1'b0;
                    end else if (r_tmo_cnt < c_tmo_max) begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    rst_busy   <= 1'b0;
                    ndm_rst_n  <= 1'b1;
                    hart_rst_n <= 1'b1;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_scr1_scu_rst_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr1_scu_rst_req_ctrl
// Purpose  : Bench for the reset-request controller with an SCU feedback model.
// Revision : 1.0
// ============================================================================
module tb_scr1_scu_rst_req_ctrl;

    typedef struct packed {
        logic [9:0] ndm_len;
        logic [9:0] hart_len;
        logic [9:0] rel_len;
        logic       tmo;
        logic       hr;
    } rec_t;

    logic clk = 1'b0;
    logic pwrup_rst_n_sync = 1'b0;
    logic dm_ndmreset_req = 1'b0;
    logic dm_hartreset_req = 1'b0;
    logic core_rst_n = 1'b1;
    logic core_rst_n_qlfy = 1'b1;
    logic havereset_clr = 1'b0;
    logic ndm_rst_n, hart_rst_n, havereset, rst_busy, rst_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    rec_t exp_q[$];
    rec_t obs_q[$];

    bit scu_stuck   = 1'b0;
    bit scu_noraise = 1'b0;
    int lo_cnt = 0;
    int hi_cnt = 0;

    int mon_nl = 0, mon_hl = 0, mon_rl = 0;
    bit mon_prev_busy = 1'b0;

    scr1_scu_rst_req_ctrl #(
        .SCR1_RSTREQ_MIN_LEN(8),
        .SCR1_RSTREQ_TIMEOUT(255)
    ) dut (
        .clk             (clk),
        .pwrup_rst_n_sync(pwrup_rst_n_sync),
        .dm_ndmreset_req (dm_ndmreset_req),
        .dm_hartreset_req(dm_hartreset_req),
        .core_rst_n      (core_rst_n),
        .core_rst_n_qlfy (core_rst_n_qlfy),
        .havereset_clr   (havereset_clr),
        .ndm_rst_n       (ndm_rst_n),
        .hart_rst_n      (hart_rst_n),
        .havereset       (havereset),
        .rst_busy        (rst_busy),
        .rst_timeout     (rst_timeout)
    );

    always #5 clk = ~clk;

    // SCU model: core reset drops 2 cycles after a request output falls, rises 3 after release.
    always @(negedge clk) begin
        if (scu_stuck) begin
            core_rst_n = 1'b1;
            lo_cnt = 0;
            hi_cnt = 0;
        end else if (!ndm_rst_n || !hart_rst_n) begin
            hi_cnt = 0;
            lo_cnt++;
            if (lo_cnt >= 2) core_rst_n = 1'b0;
        end else begin
            lo_cnt = 0;
            if (!core_rst_n && !scu_noraise) begin
                hi_cnt++;
                if (hi_cnt >= 3) begin
                    core_rst_n = 1'b1;
                    hi_cnt = 0;
                end
            end
        end
        core_rst_n_qlfy = core_rst_n;
    end

    // Monitor: measures each sequence and pushes a record when rst_busy falls.
    always @(negedge clk) begin
        if (!pwrup_rst_n_sync) begin
            mon_nl = 0; mon_hl = 0; mon_rl = 0;
            mon_prev_busy = 1'b0;
        end else begin
            if (rst_busy) begin
                if (!ndm_rst_n) mon_nl++;
                if (!hart_rst_n) mon_hl++;
                if (ndm_rst_n && hart_rst_n) mon_rl++;
            end else if (mon_prev_busy) begin
                obs_q.push_back({10'(mon_nl), 10'(mon_hl), 10'(mon_rl), rst_timeout, havereset});
                mon_nl = 0; mon_hl = 0; mon_rl = 0;
            end
            mon_prev_busy = rst_busy;
        end
    end

    function automatic rec_t mk(input int nl, input int hl, input int rl, input bit tmo, input bit hr);
        mk = {10'(nl), 10'(hl), 10'(rl), tmo, hr};
    endfunction

    task automatic wait_seq(output bit got);
        got = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk); #1;
            if (obs_q.size() != 0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk) havereset_clr = 1'b1;
        @(negedge clk) havereset_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({ndm_rst_n, hart_rst_n, havereset, rst_busy, rst_timeout} !== 5'b11100)
            $display("FAIL reset_values: got ndm/hart/hr/busy/tmo=%b required 11100",
                     {ndm_rst_n, hart_rst_n, havereset, rst_busy, rst_timeout});
        else n_pass++;
        @(negedge clk) pwrup_rst_n_sync = 1'b1;
        idle(3);
        n_checks++;
        if ({ndm_rst_n, hart_rst_n, havereset, rst_busy} !== 4'b1110)
            $display("FAIL idle_after_reset: got %b required 1110",
                     {ndm_rst_n, hart_rst_n, havereset, rst_busy});
        else n_pass++;
    endtask

    task automatic test_havereset_clr();
        pulse_clr();
        #1;
        n_checks++;
        if (havereset !== 1'b0) $display("FAIL havereset_clr: got %b required 0", havereset);
        else n_pass++;
    endtask

    task automatic test_basic_hart();
        bit got; rec_t o, e;
        pulse_clr();
        exp_q.push_back(mk(0, 8, 3, 1'b0, 1'b1));
        @(negedge clk) dm_hartreset_req = 1'b1;
        @(negedge clk) dm_hartreset_req = 1'b0;
        #1;
        n_checks++;
        if ({ndm_rst_n, hart_rst_n, rst_busy} !== 3'b101)
            $display("FAIL basic_first_cycle: got ndm/hart/busy=%b required 101",
                     {ndm_rst_n, hart_rst_n, rst_busy});
        else n_pass++;
        wait_seq(got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL basic_seq: no completion, required ndm=%0d hart=%0d", e.ndm_len, e.hart_len);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL basic_seq: got ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b required ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b",
                                  o.ndm_len, o.hart_len, o.rel_len, o.tmo, o.hr, e.ndm_len, e.hart_len, e.rel_len, e.tmo, e.hr);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        bit got; rec_t o, e;
        pulse_clr();
        exp_q.push_back(mk(8, 8, 3, 1'b0, 1'b1));
        @(negedge clk) begin dm_ndmreset_req = 1'b1; dm_hartreset_req = 1'b1; end
        @(negedge clk) begin dm_ndmreset_req = 1'b0; dm_hartreset_req = 1'b0; end
        wait_seq(got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL simultaneous_seq: no completion, required ndm=%0d hart=%0d", e.ndm_len, e.hart_len);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL simultaneous_seq: got ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b required ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b",
                                  o.ndm_len, o.hart_len, o.rel_len, o.tmo, o.hr, e.ndm_len, e.hart_len, e.rel_len, e.tmo, e.hr);
            else n_pass++;
        end
    endtask

    task automatic test_upgrade();
        bit got; rec_t o, e;
        pulse_clr();
        exp_q.push_back(mk(8, 12, 3, 1'b0, 1'b1));
        @(negedge clk) dm_hartreset_req = 1'b1;
        @(negedge clk) dm_hartreset_req = 1'b0;
        idle(3);
        dm_ndmreset_req = 1'b1;
        @(negedge clk) dm_ndmreset_req = 1'b0;
        wait_seq(got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL upgrade_seq: no completion, required ndm=%0d hart=%0d", e.ndm_len, e.hart_len);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL upgrade_seq: got ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b required ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b",
                                  o.ndm_len, o.hart_len, o.rel_len, o.tmo, o.hr, e.ndm_len, e.hart_len, e.rel_len, e.tmo, e.hr);
            else n_pass++;
        end
    endtask

    task automatic test_long_hold();
        bit got; rec_t o, e;
        pulse_clr();
        exp_q.push_back(mk(100, 0, 3, 1'b0, 1'b1));
        @(negedge clk) dm_ndmreset_req = 1'b1;
        idle(100);
        dm_ndmreset_req = 1'b0;
        wait_seq(got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL long_hold_seq: no completion, required ndm=%0d", e.ndm_len);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL long_hold_seq: got ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b required ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b",
                                  o.ndm_len, o.hart_len, o.rel_len, o.tmo, o.hr, e.ndm_len, e.hart_len, e.rel_len, e.tmo, e.hr);
            else n_pass++;
        end
    endtask

    task automatic test_assert_timeout();
        bit got; rec_t o, e;
        pulse_clr();
        scu_stuck = 1'b1;
        exp_q.push_back(mk(0, 255, 1, 1'b1, 1'b1));
        @(negedge clk) dm_hartreset_req = 1'b1;
        @(negedge clk) dm_hartreset_req = 1'b0;
        wait_seq(got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL assert_timeout_seq: no completion, required hart=%0d tmo=1", e.hart_len);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL assert_timeout_seq: got ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b required ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b",
                                  o.ndm_len, o.hart_len, o.rel_len, o.tmo, o.hr, e.ndm_len, e.hart_len, e.rel_len, e.tmo, e.hr);
            else n_pass++;
        end
        scu_stuck = 1'b0;
        idle(4);
        n_checks++;
        if (rst_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b required 1", rst_timeout);
        else n_pass++;

        // A fresh request clears the sticky timeout in its first cycle.
        exp_q.push_back(mk(0, 8, 3, 1'b0, 1'b1));
        @(negedge clk) dm_hartreset_req = 1'b1;
        @(negedge clk) dm_hartreset_req = 1'b0;
        #1;
        n_checks++;
        if ({rst_timeout, rst_busy} !== 2'b01)
            $display("FAIL timeout_cleared: got tmo/busy=%b required 01", {rst_timeout, rst_busy});
        else n_pass++;
        wait_seq(got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL after_timeout_seq: no completion, required hart=%0d", e.hart_len);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL after_timeout_seq: got ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b required ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b",
                                  o.ndm_len, o.hart_len, o.rel_len, o.tmo, o.hr, e.ndm_len, e.hart_len, e.rel_len, e.tmo, e.hr);
            else n_pass++;
        end
    endtask

    task automatic test_release_timeout();
        bit got; rec_t o, e;
        pulse_clr();
        scu_noraise = 1'b1;
        exp_q.push_back(mk(0, 8, 255, 1'b1, 1'b0));
        @(negedge clk) dm_hartreset_req = 1'b1;
        @(negedge clk) dm_hartreset_req = 1'b0;
        wait_seq(got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL release_timeout_seq: no completion, required rel=%0d", e.rel_len);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL release_timeout_seq: got ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b required ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b",
                                  o.ndm_len, o.hart_len, o.rel_len, o.tmo, o.hr, e.ndm_len, e.hart_len, e.rel_len, e.tmo, e.hr);
            else n_pass++;
        end
        scu_noraise = 1'b0;
        idle(8);
    endtask

    task automatic test_clr_vs_set();
        bit got; rec_t o, e;
        pulse_clr();
        exp_q.push_back(mk(0, 8, 3, 1'b0, 1'b1));
        @(negedge clk) dm_hartreset_req = 1'b1;
        @(negedge clk) dm_hartreset_req = 1'b0;
        // Completion edge is 11 cycles after the trigger: clear pulse lands on it.
        idle(10);
        havereset_clr = 1'b1;
        @(negedge clk) havereset_clr = 1'b0;
        wait_seq(got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL clr_vs_set_seq: no completion, required hr=1");
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL clr_vs_set_seq: got ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b required ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b",
                                  o.ndm_len, o.hart_len, o.rel_len, o.tmo, o.hr, e.ndm_len, e.hart_len, e.rel_len, e.tmo, e.hr);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_sequence();
        bit got; rec_t o, e;
        pulse_clr();
        @(negedge clk) dm_ndmreset_req = 1'b1;
        idle(4);
        pwrup_rst_n_sync = 1'b0;
        #1;
        n_checks++;
        if ({ndm_rst_n, hart_rst_n, havereset, rst_busy, rst_timeout} !== 5'b11100)
            $display("FAIL mid_reset_values: got ndm/hart/hr/busy/tmo=%b required 11100",
                     {ndm_rst_n, hart_rst_n, havereset, rst_busy, rst_timeout});
        else n_pass++;
        exp_q.push_back(mk(8, 0, 3, 1'b0, 1'b1));
        @(negedge clk) pwrup_rst_n_sync = 1'b1;
        @(negedge clk) dm_ndmreset_req = 1'b0;
        #1;
        n_checks++;
        if ({ndm_rst_n, hart_rst_n, rst_busy} !== 3'b011)
            $display("FAIL retrigger_after_reset: got ndm/hart/busy=%b required 011",
                     {ndm_rst_n, hart_rst_n, rst_busy});
        else n_pass++;
        wait_seq(got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got) $display("FAIL retrigger_seq: no completion, required ndm=%0d", e.ndm_len);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL retrigger_seq: got ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b required ndm=%0d hart=%0d rel=%0d tmo=%b hr=%b",
                                  o.ndm_len, o.hart_len, o.rel_len, o.tmo, o.hr, e.ndm_len, e.hart_len, e.rel_len, e.tmo, e.hr);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_havereset_clr();
        test_basic_hart();
        idle(3);
        test_simultaneous();
        idle(3);
        test_upgrade();
        idle(3);
        test_long_hold();
        idle(3);
        test_assert_timeout();
        idle(3);
        test_release_timeout();
        test_clr_vs_set();
        idle(3);
        test_reset_mid_sequence();
        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
